// File: rtl/fp_round_pack.sv
// fp_round_pack: normalize, RNE round, FTZ and pack for the FP add/sub path.
// One op in flight; valid/ready on both the input and output sides.
module fp_round_pack #(
   parameter int WIDTH     = 32,
   parameter int EXP_BITS  = 8,
   parameter int MANT_BITS = 23
) (
   input  logic                       clk,
   input  logic                       arst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_sign,
   input  logic signed [EXP_BITS+1:0] in_exp,
   input  logic [MANT_BITS+3:0]       in_mant,
   input  logic                       in_special,
   input  logic [WIDTH-1:0]           in_special_result,
   input  logic                       in_invalid,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           result,
   output logic [3:0]                 out_flags
);

   localparam int EW = EXP_BITS + 2;
   localparam int MW = MANT_BITS + 4;

   localparam logic signed [EW-1:0] ONE     = EW'(1);
   localparam logic signed [EW-1:0] ZERO    = '0;
   localparam logic signed [EW-1:0] EXP_MAX = EW'((2 ** EXP_BITS) - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_NORM,
      S_ROUND,
      S_DONE
   } state_t;

   state_t                state_q, state_nx;
   logic                  sign_q, sign_nx;
   logic signed [EW-1:0]  exp_q, exp_nx;
   logic [MW-1:0]         mant_q, mant_nx;
   logic [WIDTH-1:0]      result_q, result_nx;
   logic [3:0]            flags_q, flags_nx;

   logic                  c_bit;
   logic                  h_bit;
   logic                  rnd_up;
   logic                  inexact;
   logic [MW-1:0]         rnd_sum;
   logic [MW-1:0]         rnd_mant;
   logic signed [EW-1:0]  rnd_exp;

   assign c_bit = mant_q[MW-1];
   assign h_bit = mant_q[MW-2];

   // RNE increment at the fraction lsb; a carry out renormalizes by one.
   always_comb begin
      inexact  = mant_q[1] | mant_q[0];
      rnd_up   = mant_q[1] & (mant_q[0] | mant_q[2]);
      rnd_sum  = mant_q + {{(MW-3){1'b0}}, rnd_up, 2'b00};
      rnd_mant = rnd_sum;
      rnd_exp  = exp_q;
      if (rnd_sum[MW-1]) begin
         rnd_mant = rnd_sum >> 1;
         rnd_exp  = exp_q + ONE;
      end
   end

   // Next-state, datapath and packed-result logic for the op sequencer.
   always_comb begin
      state_nx  = state_q;
      sign_nx   = sign_q;
      exp_nx    = exp_q;
      mant_nx   = mant_q;
      result_nx = result_q;
      flags_nx  = flags_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               sign_nx = in_sign;
               exp_nx  = in_exp;
               mant_nx = in_mant;
               if (in_special) begin
                  result_nx = in_special_result;
                  flags_nx  = {in_invalid, 3'b000};
                  state_nx  = S_DONE;
               end else if (in_mant == '0) begin
                  result_nx = {in_sign, {(WIDTH-1){1'b0}}};
                  flags_nx  = 4'b0000;
                  state_nx  = S_DONE;
               end else begin
                  state_nx = S_NORM;
               end
            end
         end
         S_NORM: begin
            if (c_bit) begin
               mant_nx  = {1'b0, mant_q[MW-1:2], mant_q[1] | mant_q[0]};
               exp_nx   = exp_q + ONE;
               state_nx = S_ROUND;
            end else if (h_bit) begin
               state_nx = S_ROUND;
            end else if (exp_q <= ONE) begin
               state_nx = S_ROUND;
            end else begin
               mant_nx = mant_q << 1;
               exp_nx  = exp_q - ONE;
            end
         end
         S_ROUND: begin
            mant_nx  = rnd_mant;
            exp_nx   = rnd_exp;
            state_nx = S_DONE;
            if (rnd_exp >= EXP_MAX) begin
               result_nx = {sign_q, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
               flags_nx  = 4'b0101;
            end else if ((rnd_exp <= ZERO) || !rnd_mant[MW-2]) begin
               result_nx = {sign_q, {(WIDTH-1){1'b0}}};
               flags_nx  = 4'b0011;
            end else begin
               result_nx = {sign_q, rnd_exp[EXP_BITS-1:0], rnd_mant[MW-3:2]};
               flags_nx  = {3'b000, inexact};
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_nx = S_IDLE;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any op in flight.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q  <= S_IDLE;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         mant_q   <= '0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_nx;
         sign_q   <= sign_nx;
         exp_q    <= exp_nx;
         mant_q   <= mant_nx;
         result_q <= result_nx;
         flags_q  <= flags_nx;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign out_flags = flags_q;

endmodule

// File: tb/tb_fp_round_pack.sv
// tb_fp_round_pack: directed single-precision vectors for fp_round_pack.
// Checks results, flags, latency, backpressure and async reset abort.
module tb_fp_round_pack;

   logic        clk;
   logic        arst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [9:0]  in_exp;
   logic [26:0] in_mant;
   logic        in_special;
   logic [31:0] in_special_result;
   logic        in_invalid;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [3:0]  out_flags;

   int errors = 0;
   int checks = 0;

   fp_round_pack #(
      .WIDTH(32),
      .EXP_BITS(8),
      .MANT_BITS(23)
   ) dut (
      .clk(clk),
      .arst_n(arst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_sign(in_sign),
      .in_exp(in_exp),
      .in_mant(in_mant),
      .in_special(in_special),
      .in_special_result(in_special_result),
      .in_invalid(in_invalid),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result(result),
      .out_flags(out_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [26:0] M_C  = 27'h4000000;
   localparam logic [26:0] M_H  = 27'h2000000;
   localparam logic [26:0] M_F22 = 27'h1000000;
   localparam logic [26:0] M_F0 = 27'h0000004;
   localparam logic [26:0] M_G  = 27'h0000002;
   localparam logic [26:0] M_S  = 27'h0000001;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic s, input logic [9:0] e,
                           input logic [26:0] m, input logic sp,
                           input logic [31:0] spr, input logic inv);
      in_sign = s;
      in_exp = e;
      in_mant = m;
      in_special = sp;
      in_special_result = spr;
      in_invalid = inv;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_special = 1'b0;
   endtask

   task automatic wait_check(input string tag, input logic [31:0] xr,
                             input logic [3:0] xf, input int xlat);
      int lat;
      lat = 1;
      while (!out_valid && lat < 64) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_lat"}, 32'(lat), 32'(xlat));
      chk({tag, "_res"}, result, xr);
      chk({tag, "_flags"}, 32'(out_flags), 32'(xf));
   endtask

   task automatic release_out(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_drop"}, 32'(out_valid), 32'd0);
      chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
   endtask

   task automatic run_op(input string tag, input logic s,
                         input logic [9:0] e, input logic [26:0] m,
                         input logic [31:0] xr, input logic [3:0] xf,
                         input int xlat);
      start_op(s, e, m, 1'b0, 32'h0, 1'b0);
      wait_check(tag, xr, xf, xlat);
      release_out(tag);
   endtask

   initial begin
      arst_n = 1'b0;
      in_valid = 1'b0;
      in_sign = 1'b0;
      in_exp = '0;
      in_mant = '0;
      in_special = 1'b0;
      in_special_result = '0;
      in_invalid = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_result", result, 32'h0);
      chk("rst_flags", 32'(out_flags), 32'h0);
      arst_n = 1'b1;
      @(posedge clk);
      #1;

      run_op("one_plus_one", 1'b0, 10'd127, M_C, 32'h40000000, 4'h0, 3);
      run_op("neg_carry", 1'b1, 10'd127, M_C | M_G,
             32'hC0000000, 4'h1, 3);
      run_op("half", 1'b0, 10'd127, M_F22, 32'h3F000000, 4'h0, 4);
      run_op("tie_even", 1'b0, 10'd127, M_H | M_G,
             32'h3F800000, 4'h1, 3);
      run_op("tie_odd", 1'b0, 10'd127, M_H | M_F0 | M_G,
             32'h3F800002, 4'h1, 3);
      run_op("above_half", 1'b0, 10'd127, M_H | M_G | M_S,
             32'h3F800001, 4'h1, 3);
      run_op("ovf", 1'b0, 10'd254, 27'h3FFFFFE,
             32'h7F800000, 4'h5, 3);
      run_op("tiny_neg_exp", 1'b1, 10'h3FD, M_H,
             32'h80000000, 4'h3, 3);
      run_op("min_normal", 1'b0, 10'd2, M_F22, 32'h00800000, 4'h0, 4);
      run_op("stop_at_one", 1'b0, 10'd1, M_F22, 32'h00000000, 4'h3, 3);
      run_op("long_shift", 1'b0, 10'd127, M_F0, 32'h34000000, 4'h0, 26);
      run_op("zero_mant", 1'b1, 10'd50, 27'h0, 32'h80000000, 4'h0, 1);

      start_op(1'b0, 10'd0, 27'h0, 1'b1, 32'h7FC00000, 1'b1);
      wait_check("special", 32'h7FC00000, 4'h8, 1);
      release_out("special");

      start_op(1'b0, 10'd127, M_H | M_G, 1'b0, 32'h0, 1'b0);
      wait_check("hold", 32'h3F800000, 4'h1, 3);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_mant = M_C;
         @(posedge clk);
         #1;
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_ready", 32'(in_ready), 32'd0);
         chk("hold_res", result, 32'h3F800000);
         chk("hold_flags", 32'(out_flags), 32'h1);
      end
      in_valid = 1'b0;
      release_out("hold");
      @(posedge clk);
      #1;
      chk("hold_no_new", 32'(out_valid), 32'd0);

      start_op(1'b0, 10'd127, M_F0, 1'b0, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      arst_n = 1'b0;
      #2;
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_ready", 32'(in_ready), 32'd1);
      chk("abort_res", result, 32'h0);
      #1;
      arst_n = 1'b1;
      @(posedge clk);
      #1;
      run_op("after_rst", 1'b0, 10'd127, M_C, 32'h40000000, 4'h0, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
